// File: rtl/fifo_mem_prog.sv
// fifo_mem_prog: single-clock FIFO with arbitrary depth, exported fill level,
// programmable almost-full/almost-empty thresholds and sticky, clearable error flags.
// Optional first-word-fall-through read mode: define FIFO_MEM_PROG_FWFT_EN.
`default_nettype none

module fifo_mem_prog #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 18,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_in,
  input  logic                  areset_b,
  input  logic                  trans_write,
  input  logic                  trans_read,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  err_clr,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [CNT_W-1:0]      fill_level,
  output logic                  full_ind,
  output logic                  empty_ind,
  output logic                  almost_full_ind,
  output logic                  almost_empty_ind,
  output logic                  overflow_ind,
  output logic                  underflow_ind
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             rd_acc;
  logic             wr_acc;

  assign empty_ind = (count_q == '0);
  assign full_ind  = (count_q == CNT_FULL);

  // A read frees a slot in the same edge, so a full FIFO still accepts a paired write.
  assign rd_acc = trans_read && !empty_ind;
  assign wr_acc = trans_write && (!full_ind || rd_acc);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (wr_acc) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A fresh error in the clearing cycle keeps the flag set.
    ovf_d = (ovf_q && !err_clr) || (trans_write && !wr_acc);
    unf_d = (unf_q && !err_clr) || (trans_read && empty_ind);
  end

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone decide what is reachable.
  always_ff @(posedge clk_in) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= data_in;
    end
  end

`ifdef FIFO_MEM_PROG_FWFT_EN
  assign data_out   = empty_ind ? '0 : mem_q[rptr_q];
  assign data_valid = !empty_ind;
`else
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dvalid_q;

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dvalid_q <= rd_acc;
      if (rd_acc) begin
        dout_q <= mem_q[rptr_q];
      end
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dvalid_q;
`endif

  assign fill_level       = count_q;
  assign almost_full_ind  = (count_q >= af_thresh);
  assign almost_empty_ind = (count_q <= ae_thresh);
  assign overflow_ind     = ovf_q;
  assign underflow_ind    = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_mem_prog.sv
// Self-checking bench for fifo_mem_prog: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
`default_nettype none

module tb_fifo_mem_prog;

  localparam int DW    = 16;
  localparam int DEPTH = 18;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_in = 1'b0;
  logic          areset_b;
  logic          trans_write;
  logic          trans_read;
  logic [DW-1:0] data_in;
  logic          err_clr;
  logic [CW-1:0] af_thresh;
  logic [CW-1:0] ae_thresh;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [CW-1:0] fill_level;
  logic          full_ind;
  logic          empty_ind;
  logic          almost_full_ind;
  logic          almost_empty_ind;
  logic          overflow_ind;
  logic          underflow_ind;

  fifo_mem_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_in           (clk_in),
    .areset_b         (areset_b),
    .trans_write      (trans_write),
    .trans_read       (trans_read),
    .data_in          (data_in),
    .err_clr          (err_clr),
    .af_thresh        (af_thresh),
    .ae_thresh        (ae_thresh),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .fill_level       (fill_level),
    .full_ind         (full_ind),
    .empty_ind        (empty_ind),
    .almost_full_ind  (almost_full_ind),
    .almost_empty_ind (almost_empty_ind),
    .overflow_ind     (overflow_ind),
    .underflow_ind    (underflow_ind)
  );

  always #5 clk_in = ~clk_in;

  int errs   = 0;
  int checks = 0;

  // Reference model: contents as a queue, plus stickies and last popped word.
  logic [DW-1:0] q[$];
  bit            m_ovf;
  bit            m_unf;
  bit            m_valid;
  logic [DW-1:0] m_dout;

  function automatic logic [DW-1:0] exp_dout();
`ifdef FIFO_MEM_PROG_FWFT_EN
    return (q.size() > 0) ? q[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  function automatic bit exp_valid();
`ifdef FIFO_MEM_PROG_FWFT_EN
    return q.size() > 0;
`else
    return m_valid;
`endif
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovf   = 0;
    m_unf   = 0;
    m_valid = 0;
    m_dout  = '0;
  endfunction

  // Drive one cycle of requests, advance the model at the edge, sample 1ns later.
  task automatic step(input bit wr, input bit rd, input bit clr, input logic [DW-1:0] din);
    bit rd_ok, wr_ok, was_empty;
    trans_write = wr;
    trans_read  = rd;
    err_clr     = clr;
    data_in     = din;
    @(posedge clk_in);
    was_empty = (q.size() == 0);
    rd_ok     = rd && !was_empty;
    wr_ok     = wr && (q.size() < DEPTH || rd_ok);
    m_valid   = 0;
    if (rd_ok) begin
      m_dout  = q.pop_front();
      m_valid = 1;
    end
    if (wr_ok) q.push_back(din);
    m_ovf = (m_ovf && !clr) || (wr && !wr_ok);
    m_unf = (m_unf && !clr) || (rd && was_empty);
    #1;
    trans_write = 0;
    trans_read  = 0;
    err_clr     = 0;
  endtask

  task automatic test_reset();
    areset_b    = 0;
    trans_write = 0;
    trans_read  = 0;
    err_clr     = 0;
    data_in     = '0;
    af_thresh   = '0;
    ae_thresh   = CW'(2);
    model_reset();
    #12;
    checks++; if (fill_level !== 0) begin errs++; $display("FAIL reset_level got %0d want 0", fill_level); end
    checks++; if (empty_ind !== 1'b1 || full_ind !== 1'b0) begin errs++; $display("FAIL reset_empty_full got %b%b want 10", empty_ind, full_ind); end
    checks++; if (almost_full_ind !== 1'b1) begin errs++; $display("FAIL reset_af_zero_thresh got %b want 1", almost_full_ind); end
    checks++; if (almost_empty_ind !== 1'b1) begin errs++; $display("FAIL reset_ae got %b want 1", almost_empty_ind); end
    checks++; if (data_out !== 0 || data_valid !== 1'b0) begin errs++; $display("FAIL reset_dout got %h/%b want 0000/0", data_out, data_valid); end
    checks++; if (overflow_ind !== 1'b0 || underflow_ind !== 1'b0) begin errs++; $display("FAIL reset_sticky got %b%b want 00", overflow_ind, underflow_ind); end
    af_thresh = CW'(9);
    #1;
    checks++; if (almost_full_ind !== 1'b0) begin errs++; $display("FAIL reset_af_thresh9 got %b want 0", almost_full_ind); end
    @(negedge clk_in);
    areset_b = 1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 17; i++) begin
      step(1, 0, 0, DW'(i));
      checks++; if (fill_level !== CW'(i)) begin errs++; $display("FAIL fill_level got %0d want %0d", fill_level, i); end
    end
    for (int i = 1; i <= 17; i++) begin
`ifdef FIFO_MEM_PROG_FWFT_EN
      checks++; if (data_out !== DW'(i) || data_valid !== 1'b1) begin errs++; $display("FAIL fwft_head got %h/%b want %h/1", data_out, data_valid, DW'(i)); end
`endif
      step(0, 1, 0, '0);
`ifndef FIFO_MEM_PROG_FWFT_EN
      checks++; if (data_out !== DW'(i) || data_valid !== 1'b1) begin errs++; $display("FAIL drain_data got %h/%b want %h/1", data_out, data_valid, DW'(i)); end
`endif
    end
    checks++; if (fill_level !== 0 || empty_ind !== 1'b1) begin errs++; $display("FAIL drain_end got %0d/%b want 0/1", fill_level, empty_ind); end
    checks++; if (overflow_ind !== 1'b0 || underflow_ind !== 1'b0) begin errs++; $display("FAIL drain_sticky got %b%b want 00", overflow_ind, underflow_ind); end
    step(0, 0, 0, '0);
    checks++; if (data_valid !== 1'b0) begin errs++; $display("FAIL idle_valid got %b want 0", data_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 18; i++) step(1, 0, 0, DW'(i));
    checks++; if (full_ind !== 1'b1 || overflow_ind !== 1'b0) begin errs++; $display("FAIL full_no_ovf got %b%b want 10", full_ind, overflow_ind); end
    step(1, 0, 0, 16'h00FF);
    checks++; if (full_ind !== 1'b1 || overflow_ind !== 1'b1 || fill_level !== CW'(18)) begin errs++; $display("FAIL ovf_set got full=%b ovf=%b lvl=%0d want 1 1 18", full_ind, overflow_ind, fill_level); end
    for (int i = 1; i <= 18; i++) begin
      step(0, 1, 0, '0);
      checks++; if (m_dout !== DW'(i) || data_out !== exp_dout() || data_valid !== exp_valid()) begin errs++; $display("FAIL ovf_drain got %h/%b want %h/%b", data_out, data_valid, exp_dout(), exp_valid()); end
    end
    checks++; if (overflow_ind !== 1'b1 || empty_ind !== 1'b1) begin errs++; $display("FAIL ovf_sticky got ovf=%b empty=%b want 1 1", overflow_ind, empty_ind); end
    step(0, 0, 1, '0);
    checks++; if (overflow_ind !== 1'b0) begin errs++; $display("FAIL ovf_clear got %b want 0", overflow_ind); end
  endtask

  task automatic test_underflow();
    step(0, 1, 0, '0);
    checks++; if (underflow_ind !== 1'b1 || fill_level !== 0) begin errs++; $display("FAIL unf_set got %b/%0d want 1/0", underflow_ind, fill_level); end
    checks++; if (data_out !== exp_dout() || data_valid !== 1'b0) begin errs++; $display("FAIL unf_hold got %h/%b want %h/0", data_out, data_valid, exp_dout()); end
    step(1, 1, 0, 16'h0AAA);
    checks++; if (fill_level !== CW'(1) || underflow_ind !== 1'b1) begin errs++; $display("FAIL unf_rw got %0d/%b want 1/1", fill_level, underflow_ind); end
    step(0, 1, 0, '0);
    checks++; if (m_dout !== 16'h0AAA || data_out !== exp_dout()) begin errs++; $display("FAIL unf_next got %h want %h", data_out, exp_dout()); end
    // Set wins over a simultaneous clear.
    step(0, 1, 1, '0);
    checks++; if (underflow_ind !== 1'b1) begin errs++; $display("FAIL unf_set_wins got %b want 1", underflow_ind); end
    step(0, 0, 1, '0);
    checks++; if (underflow_ind !== 1'b0) begin errs++; $display("FAIL unf_clear got %b want 0", underflow_ind); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) step(1, 0, 0, DW'(16'h0100 + i));
    for (int i = 0; i < 10; i++) step(0, 1, 0, '0);
    for (int i = 0; i < 18; i++) step(1, 0, 0, DW'(16'h0200 + i));
    checks++; if (full_ind !== 1'b1) begin errs++; $display("FAIL wrap_full got %b want 1", full_ind); end
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, DW'(16'h0300 + i));
      checks++; if (fill_level !== CW'(18) || overflow_ind !== 1'b0 || data_out !== exp_dout()) begin errs++; $display("FAIL wrap_rw_full got lvl=%0d ovf=%b d=%h want 18 0 %h", fill_level, overflow_ind, data_out, exp_dout()); end
    end
    while (q.size() > 0) begin
      step(0, 1, 0, '0);
      checks++; if (data_out !== exp_dout() || data_valid !== exp_valid()) begin errs++; $display("FAIL wrap_order got %h/%b want %h/%b", data_out, data_valid, exp_dout(), exp_valid()); end
    end
    checks++; if (empty_ind !== 1'b1) begin errs++; $display("FAIL wrap_empty got %b want 1", empty_ind); end
  endtask

  task automatic test_thresholds();
    af_thresh = CW'(9);
    ae_thresh = CW'(2);
    for (int lvl = 0; lvl <= 18; lvl++) begin
      if (lvl > 0) step(1, 0, 0, DW'(lvl));
      checks++; if (almost_full_ind !== (lvl >= 9) || almost_empty_ind !== (lvl <= 2)) begin errs++; $display("FAIL thr_up lvl=%0d got af=%b ae=%b", lvl, almost_full_ind, almost_empty_ind); end
    end
    af_thresh = CW'(31);
    #1;
    checks++; if (almost_full_ind !== 1'b0) begin errs++; $display("FAIL thr_above_depth got %b want 0", almost_full_ind); end
    af_thresh = CW'(9);
    for (int lvl = 17; lvl >= 0; lvl--) begin
      step(0, 1, 0, '0);
      checks++; if (almost_full_ind !== (lvl >= 9) || almost_empty_ind !== (lvl <= 2)) begin errs++; $display("FAIL thr_down lvl=%0d got af=%b ae=%b", lvl, almost_full_ind, almost_empty_ind); end
    end
  endtask

  task automatic test_random();
    int wr_pct;
    for (int n = 0; n < 600; n++) begin
      wr_pct = ((n / 100) % 2 == 0) ? 70 : 30;
      if (n % 50 == 0) begin
        af_thresh = CW'($urandom_range(0, 31));
        ae_thresh = CW'($urandom_range(0, 31));
      end
      step($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 5, DW'($urandom));
      checks++;
      if (fill_level !== CW'(q.size()) || full_ind !== (q.size() == DEPTH) || empty_ind !== (q.size() == 0) ||
          almost_full_ind !== (q.size() >= int'(af_thresh)) || almost_empty_ind !== (q.size() <= int'(ae_thresh))) begin
        errs++;
        $display("FAIL rand_level n=%0d got lvl=%0d f=%b e=%b af=%b ae=%b want lvl=%0d", n, fill_level, full_ind, empty_ind, almost_full_ind, almost_empty_ind, q.size());
      end
      checks++;
      if (data_out !== exp_dout() || data_valid !== exp_valid() || overflow_ind !== m_ovf || underflow_ind !== m_unf) begin
        errs++;
        $display("FAIL rand_data n=%0d got d=%h v=%b o=%b u=%b want d=%h v=%b o=%b u=%b", n, data_out, data_valid, overflow_ind, underflow_ind, exp_dout(), exp_valid(), m_ovf, m_unf);
      end
    end
  endtask

  task automatic test_async_reset();
    while (q.size() > 0) step(0, 1, 0, '0);
    step(0, 0, 1, '0);
    af_thresh = CW'(9);
    ae_thresh = CW'(2);
    for (int i = 0; i < 7; i++) step(1, 0, 0, DW'(16'h0500 + i));
    step(1, 1, 0, 16'h0507);
    checks++; if (fill_level !== CW'(7)) begin errs++; $display("FAIL pre_reset_level got %0d want 7", fill_level); end
    trans_write = 1;
    data_in     = 16'h0BAD;
    #2;
    areset_b = 0;
    model_reset();
    #1;
    checks++; if (fill_level !== 0 || empty_ind !== 1'b1 || full_ind !== 1'b0) begin errs++; $display("FAIL areset_level got %0d/%b/%b want 0/1/0", fill_level, empty_ind, full_ind); end
    checks++; if (data_out !== 0 || data_valid !== 1'b0 || overflow_ind !== 1'b0 || underflow_ind !== 1'b0) begin errs++; $display("FAIL areset_outs got %h/%b/%b/%b want 0/0/0/0", data_out, data_valid, overflow_ind, underflow_ind); end
    checks++; if (almost_empty_ind !== 1'b1 || almost_full_ind !== 1'b0) begin errs++; $display("FAIL areset_thr got ae=%b af=%b want 1 0", almost_empty_ind, almost_full_ind); end
    @(posedge clk_in);
    #1;
    checks++; if (fill_level !== 0) begin errs++; $display("FAIL areset_held got %0d want 0", fill_level); end
    trans_write = 0;
    @(negedge clk_in);
    areset_b = 1;
    step(1, 0, 0, 16'h1234);
    checks++; if (data_out !== exp_dout() || data_valid !== exp_valid() || fill_level !== CW'(1)) begin errs++; $display("FAIL post_reset_write got %h/%b/%0d want %h/%b/1", data_out, data_valid, fill_level, exp_dout(), exp_valid()); end
    step(0, 1, 0, '0);
    checks++; if (m_dout !== 16'h1234 || data_out !== exp_dout() || data_valid !== exp_valid()) begin errs++; $display("FAIL post_reset_read got %h/%b want %h/%b", data_out, data_valid, exp_dout(), exp_valid()); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_thresholds();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire
